// File: rtl/alu_seq_param_if.sv
// Handshake bundle for alu_seq_param: operand issue (in_*) and result writeback (out_*).
// The master side issues operands and consumes results; the slave side is the ALU.
interface alu_seq_param_if #(
    parameter int WIDTH = 8
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2:0]         opcode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               carry;
    logic               zero;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, carry, zero
    );
endinterface

// File: rtl/alu_seq_param.sv
// Registered, parametrised ALU with valid/ready handshakes on both sides.
// Logic ops finish at the accept edge; multiply is a WIDTH-cycle shift-add.
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_seq_param_if.slave  bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [RW-1:0]     mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [RW-1:0]     acc_r;
    logic [RW-1:0]     acc_nx_s;
    logic [CW-1:0]     cnt_r;
    logic              mul_last_s;
    logic [RW-1:0]     result_r;
    logic              carry_r;
    logic              zero_r;
    logic              out_valid_r;
    logic [RW-1:0]     alu_res_s;
    logic              alu_carry_s;

    // Single-cycle ops; returns {carry, result}. Multiply is handled by the iterative path.
    function automatic logic [RW:0] alu_eval(input logic [2:0] op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
        logic [WIDTH:0] sum;
        logic [RW:0]    r;
        sum = {1'b0, x} + {1'b0, y};
        case (op)
            OP_ADD:  r = {sum[WIDTH], {(WIDTH-1){1'b0}}, sum};
            OP_SUB:  r = {(x < y), {WIDTH{1'b0}}, x - y};
            OP_AND:  r = {1'b0, {WIDTH{1'b0}}, x & y};
            OP_OR:   r = {1'b0, {WIDTH{1'b0}}, x | y};
            OP_NOT:  r = {1'b0, {WIDTH{1'b0}}, ~x};
            OP_XOR:  r = {1'b0, {WIDTH{1'b0}}, x ^ y};
            OP_XNOR: r = {1'b0, {WIDTH{1'b0}}, ~(x ^ y)};
            default: r = {(RW+1){1'b0}};
        endcase
        return r;
    endfunction

    // Combinational result of the operation presented on the inputs.
    always_comb begin
        {alu_carry_s, alu_res_s} = alu_eval(bus.opcode, bus.a, bus.b);
    end

    // One shift-add step; the step with cnt_r==1 is the last and lands in DONE.
    always_comb begin
        acc_nx_s   = acc_r + (mplier_r[0] ? mcand_r : {RW{1'b0}});
        mul_last_s = (cnt_r == CW'(1));
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx_s = (bus.opcode == OP_MUL) ? MUL : DONE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            MUL: begin
                if (mul_last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = MUL;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath: operand capture, multiplier iteration and held result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r     <= {RW{1'b0}};
            mplier_r    <= {WIDTH{1'b0}};
            acc_r       <= {RW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            result_r    <= {RW{1'b0}};
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && (bus.opcode == OP_MUL)) begin
                        mcand_r  <= {{WIDTH{1'b0}}, bus.a};
                        mplier_r <= bus.b;
                        acc_r    <= {RW{1'b0}};
                        cnt_r    <= CW'(WIDTH);
                    end else if (bus.in_valid) begin
                        result_r    <= alu_res_s;
                        carry_r     <= alu_carry_s;
                        zero_r      <= (alu_res_s == {RW{1'b0}});
                        out_valid_r <= 1'b1;
                    end
                end
                MUL: begin
                    acc_r    <= acc_nx_s;
                    mcand_r  <= {mcand_r[RW-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r - CW'(1);
                    if (mul_last_s) begin
                        result_r    <= acc_nx_s;
                        carry_r     <= 1'b0;
                        zero_r      <= (acc_nx_s == {RW{1'b0}});
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = zero_r;
endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param (WIDTH=8): arithmetic reference model with a per-cycle
// compare process, plus hand-computed literals per operation.
module tb_alu_seq_param;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always #5 clk = ~clk;

    alu_seq_param_if #(.WIDTH(W)) bus ();

    alu_seq_param #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: {carry, 16-bit result} from plain integer arithmetic.
    function automatic logic [16:0] model(input int op, input int x, input int y);
        int mask;
        int r;
        logic c;
        mask = (1 << W) - 1;
        c = 1'b0;
        case (op)
            0: begin r = x + y; c = r[W]; end
            1: begin r = (x - y) & mask; c = (x < y); end
            2: r = x * y;
            3: r = x & y;
            4: r = x | y;
            5: r = (~x) & mask;
            6: r = x ^ y;
            default: r = (~(x ^ y)) & mask;
        endcase
        return {c, r[15:0]};
    endfunction

    // Per-cycle compare against the transaction-level model.
    initial begin
        int mst;
        int due;
        logic [15:0] er, hr;
        logic ec, hc, hz;
        mst = 0; due = 0; er = 16'd0; hr = 16'd0; ec = 1'b0; hc = 1'b0; hz = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mst = 0; hr = 16'd0; hc = 1'b0; hz = 1'b0;
            end else begin
                if (mst == 2 && bus.out_ready) begin
                    mst = 0;
                end else if (mst == 0 && bus.in_valid) begin
                    {ec, er} = model(int'(bus.opcode), int'(bus.a), int'(bus.b));
                    due = cyc + ((bus.opcode == 3'd2) ? W : 0);
                    mst = 1;
                end
                if (mst == 1 && cyc == due) begin
                    mst = 2; hr = er; hc = ec; hz = (er == 16'd0);
                end
            end
            check("cmp_out_valid", 64'(bus.out_valid), 64'(mst == 2));
            check("cmp_in_ready",  64'(bus.in_ready),  64'(mst == 0));
            check("cmp_result",    64'(bus.result),    64'(hr));
            check("cmp_carry",     64'(bus.carry),     64'(hc));
            check("cmp_zero",      64'(bus.zero),      64'(hz));
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] lr, input logic lc, input logic lz, input int hold);
        int acc_edge;
        int t;
        check("model_pin", 64'(model(int'(op), int'(x), int'(y))), 64'({lc, lr}));
        @(negedge clk);
        bus.a = x; bus.b = y; bus.opcode = op; bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 40) begin @(negedge clk); t++; end
        check("accept_timeout", 64'(bus.in_ready), 64'd1);
        acc_edge = cyc + 1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = ~x; bus.b = ~y;
        t = 0;
        while (!bus.out_valid && t < 40) begin @(negedge clk); t++; end
        check("latency", 64'(cyc - acc_edge + 1), 64'((op == 3'd2) ? W + 1 : 1));
        check("lit_result", 64'(bus.result), 64'(lr));
        check("lit_carry",  64'(bus.carry),  64'(lc));
        check("lit_zero",   64'(bus.zero),   64'(lz));
        // Held result under backpressure while a second request knocks.
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1; bus.opcode = 3'd0; bus.a = 8'd1; bus.b = 8'd2;
            @(negedge clk);
            check("hold_result", 64'(bus.result), 64'(lr));
            check("hold_valid",  64'(bus.out_valid), 64'd1);
            check("hold_ready",  64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("drain_valid", 64'(bus.out_valid), 64'd0);
        check("drain_ready", 64'(bus.in_ready), 64'd1);
        check("drain_keep",  64'(bus.result), 64'(lr));
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = 8'd0; bus.b = 8'd0; bus.opcode = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_carry",     64'(bus.carry),     64'd0);
        check("rst_zero",      64'(bus.zero),      64'd0);
        rst_n = 1'b1;

        run_op(3'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 0);
        run_op(3'd1, 8'd5,   8'd7,   16'h00FE, 1'b1, 1'b0, 2);
        run_op(3'd1, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b1, 0);
        run_op(3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 0);
        run_op(3'd2, 8'd0,   8'd37,  16'h0000, 1'b0, 1'b1, 0);
        run_op(3'd2, 8'd13,  8'd11,  16'h008F, 1'b0, 1'b0, 1);
        run_op(3'd7, 8'hAA,  8'hAA,  16'h00FF, 1'b0, 1'b0, 4);

        // Abort a multiply part-way with reset.
        @(negedge clk);
        bus.a = 8'd200; bus.b = 8'd3; bus.opcode = 3'd2; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mul_busy_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_valid",  64'(bus.out_valid), 64'd0);
        check("abort_result", 64'(bus.result),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd0, 8'd1,   8'd1,   16'h0002, 1'b0, 1'b0, 0);
        run_op(3'd5, 8'h0F,  8'hFF,  16'h00F0, 1'b0, 1'b0, 0);
        run_op(3'd4, 8'h00,  8'h00,  16'h0000, 1'b0, 1'b1, 0);
        run_op(3'd6, 8'h3C,  8'h0F,  16'h0033, 1'b0, 1'b0, 1);
        run_op(3'd3, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0, 0);
        run_op(3'd0, 8'hFF,  8'h01,  16'h0100, 1'b1, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
